mcdatamem: RTL and testbench

MCDATAMEM -- requirements
Module: mcdatamem

---
 rtl/mcdatamem.sv | 179 +++++++++++++++++
 tb/tb_mcdatamem.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mcdatamem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mcdatamem                                                      |
// | Purpose  : Multi-cycle byte-addressable 32-bit data memory with           |
// |            configurable wait states and fault reporting.                  |
// | Options  : define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word     |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module mcdatamem #(
   parameter int ADDR_W      = 13,
   parameter int DEPTH       = 2048,
   parameter int WAIT_STATES = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              sext,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              ready,
   output logic [31:0]       rdata,
   output logic              busy,
   output logic              err
);

   localparam int            IDX_W    = ADDR_W - 2;
   localparam int            MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(DEPTH);
   localparam logic [3:0]    CNT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        state;
   logic [1:0]        next_state;
   logic [3:0]        cnt;

   logic [ADDR_W-1:0] cap_addr;
   logic              cap_we;
   logic [1:0]        cap_size;
   logic              cap_sext;
   logic [31:0]       cap_wdata;

   logic [31:0]       mem [DEPTH];

   logic              live;
   logic [ADDR_W-1:0] acc_addr;
   logic              acc_we;
   logic [1:0]        acc_size;
   logic              acc_sext;
   logic [31:0]       acc_wdata;
   logic [IDX_W-1:0]  idx;
   logic [1:0]        lane;
   logic              misalign;
   logic              fault;
   logic              entering_done;
   logic [31:0]       rd_word;
   logic [7:0]        sel_byte;
   logic [15:0]       sel_half;
   logic [31:0]       load_val;
   logic [3:0]        be;
   logic [31:0]       wd;

   // ---------------- state register ----------------
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= next_state;
         if (state == S_IDLE && req)
            cnt <= CNT_INIT;
         else if (state == S_WAIT && cnt != 4'd0)
            cnt <= cnt - 4'd1;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (req) next_state = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
         S_WAIT:  if (cnt == 4'd0) next_state = S_DONE;
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // ---------------- FSM outputs ----------------
   always_comb begin
      ready = (state == S_DONE);
      busy  = (state != S_IDLE);
   end

   always_ff @(posedge clock) begin
      if (state == S_IDLE && req) begin
         cap_addr  <= addr;
         cap_we    <= we;
         cap_size  <= size;
         cap_sext  <= sext;
         cap_wdata <= wdata;
      end
   end

   // With zero wait states the access completes on its accept edge, so the
   // live inputs stand in for the captured copy while still in IDLE.
   always_comb begin
      live      = (state == S_IDLE);
      acc_addr  = live ? addr  : cap_addr;
      acc_we    = live ? we    : cap_we;
      acc_size  = live ? size  : cap_size;
      acc_sext  = live ? sext  : cap_sext;
      acc_wdata = live ? wdata : cap_wdata;
      idx       = acc_addr[ADDR_W-1:2];
      case (acc_size)
         2'b01:   lane = {acc_addr[1], 1'b0};
         2'b10:   lane = 2'b00;
         default: lane = acc_addr[1:0];
      endcase
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign = (acc_size == 2'b01 && acc_addr[0]) ||
                 (acc_size == 2'b10 && acc_addr[1:0] != 2'b00);
`else
      misalign = 1'b0;
`endif
      fault         = ({1'b0, idx} >= DEPTH_C) || (acc_size == 2'b11) || misalign;
      entering_done = (next_state == S_DONE) && (state != S_DONE);
   end

   always_comb begin
      rd_word  = mem[idx[MEM_AW-1:0]];
      sel_byte = rd_word[{lane, 3'b000} +: 8];
      sel_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
      case (acc_size)
         2'b00:   load_val = {{24{acc_sext & sel_byte[7]}}, sel_byte};
         2'b01:   load_val = {{16{acc_sext & sel_half[15]}}, sel_half};
         default: load_val = rd_word;
      endcase
      case (acc_size)
         2'b00: begin
            be = 4'b0001 << lane;
            wd = {4{acc_wdata[7:0]}};
         end
         2'b01: begin
            be = lane[1] ? 4'b1100 : 4'b0011;
            wd = {2{acc_wdata[15:0]}};
         end
         default: begin
            be = 4'b1111;
            wd = acc_wdata;
         end
      endcase
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clock) begin
      if (reset && entering_done && acc_we && !fault) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b])
               mem[idx[MEM_AW-1:0]][8*b +: 8] <= wd[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         rdata <= 32'd0;
         err   <= 1'b0;
      end else if (entering_done) begin
         err   <= fault;
         rdata <= (fault || acc_we) ? 32'd0 : load_val;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mcdatamem.sv
`default_nettype none
// tb_mcdatamem: directed scoreboard bench for mcdatamem (ADDR_W=14, DEPTH=1024,
// WAIT_STATES=2).
module tb_mcdatamem;
   localparam int ADDR_W = 14;
   localparam int WS     = 2;

   typedef struct {
      logic [31:0] rd;
      logic        er;
      logic        chk;
      string       tag;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              req = 1'b0;
   logic              we = 1'b0;
   logic [1:0]        size = 2'b10;
   logic              sext = 1'b0;
   logic [ADDR_W-1:0] addr = '0;
   logic [31:0]       wdata = '0;
   logic              ready;
   logic [31:0]       rdata;
   logic              busy;
   logic              err;

   int   asserts = 0;
   int   fails   = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   mcdatamem #(.ADDR_W(ADDR_W), .DEPTH(1024), .WAIT_STATES(WS)) dut (
      .clock(clk), .reset(reset), .req(req), .we(we), .size(size), .sext(sext),
      .addr(addr), .wdata(wdata), .ready(ready), .rdata(rdata), .busy(busy), .err(err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      asserts++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic access(input string tag, input logic w, input logic [1:0] sz,
                         input logic sx, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input logic chk_rd,
                         input bit extra_req);
      exp_t e;
      int   n;
      int   extra;
      logic busy1;
      e.rd = exp_rd; e.er = exp_err; e.chk = chk_rd; e.tag = tag;
      sb.push_back(e);
      @(negedge clk);
      req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
      @(posedge clk);
      #1;
      // scramble inputs after accept; the access must use the captured copy
      req = 1'b0; we = ~w; size = sz ^ 2'b01; sext = ~sx; addr = ~a; wdata = ~wd;
      n = 0;
      busy1 = 1'b0;
      while (n < 20) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            busy1 = busy;
            if (extra_req) req = 1'b1;
         end
         if (n == 2) req = 1'b0;
         if (ready) break;
      end
      e = sb.pop_front();
      check({e.tag, "/latency"}, n, WS + 1);
      check({e.tag, "/busy_wait"}, {31'd0, busy1}, 32'd1);
      check({e.tag, "/busy_done"}, {31'd0, busy}, 32'd1);
      check({e.tag, "/err"}, {31'd0, err}, {31'd0, e.er});
      if (e.chk) check({e.tag, "/rdata"}, rdata, e.rd);
      extra = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (ready) extra++;
         if (i == 0) check({e.tag, "/busy_after"}, {31'd0, busy}, 32'd0);
      end
      check({e.tag, "/extra_ready"}, extra, 0);
      if (e.chk) check({e.tag, "/rdata_hold"}, rdata, e.rd);
   endtask

   initial begin
      int extra;
      repeat (3) @(negedge clk);
      check("rst/ready", {31'd0, ready}, 32'd0);
      check("rst/busy",  {31'd0, busy},  32'd0);
      check("rst/err",   {31'd0, err},   32'd0);
      check("rst/rdata", rdata, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      access("st_w10",   1, 2'b10, 0, 14'h010, 32'hDEADBEEF, 0, 0, 0, 0);
      access("ld_w10",   0, 2'b10, 0, 14'h010, 0, 32'hDEADBEEF, 0, 1, 0);
      access("st_w10b",  1, 2'b10, 0, 14'h010, 32'h11223344, 0, 0, 0, 0);
      access("st_b13",   1, 2'b00, 0, 14'h013, 32'hFFFFFF80, 0, 0, 0, 0);
      access("ld_w10c",  0, 2'b10, 1, 14'h010, 0, 32'h80223344, 0, 1, 0);
      access("ld_b13s",  0, 2'b00, 1, 14'h013, 0, 32'hFFFFFF80, 0, 1, 0);
      access("ld_b13u",  0, 2'b00, 0, 14'h013, 0, 32'h00000080, 0, 1, 0);
      access("st_w20",   1, 2'b10, 0, 14'h020, 32'h12345678, 0, 0, 0, 0);
      access("st_h22",   1, 2'b01, 0, 14'h022, 32'h0000BEEF, 0, 0, 0, 0);
      access("ld_h22s",  0, 2'b01, 1, 14'h022, 0, 32'hFFFFBEEF, 0, 1, 0);
      access("ld_w20",   0, 2'b10, 0, 14'h020, 0, 32'hBEEF5678, 0, 1, 0);
      access("ld_h20u",  0, 2'b01, 0, 14'h020, 0, 32'h00005678, 0, 1, 0);
      access("ld_b21s",  0, 2'b00, 1, 14'h021, 0, 32'h00000056, 0, 1, 0);
      access("ld_oob",   0, 2'b10, 0, 14'h2000, 0, 32'h0, 1, 1, 0);
      access("st_sz11",  1, 2'b11, 0, 14'h010, 32'hA5A5A5A5, 32'h0, 1, 1, 0);
      access("ld_sz11",  0, 2'b11, 0, 14'h010, 0, 32'h0, 1, 1, 0);
      access("ld_w10d",  0, 2'b10, 0, 14'h010, 0, 32'h80223344, 0, 1, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
      access("ld_w12",   0, 2'b10, 0, 14'h012, 0, 32'h0, 1, 1, 0);
`else
      access("ld_w12",   0, 2'b10, 0, 14'h012, 0, 32'h80223344, 0, 1, 0);
`endif
      access("ld_dbl",   0, 2'b10, 0, 14'h020, 0, 32'hBEEF5678, 0, 1, 1);

      // abandon a store by resetting during WAIT
      access("st_w30",   1, 2'b10, 0, 14'h030, 32'h55AA55AA, 0, 0, 0, 0);
      access("ld_w30",   0, 2'b10, 0, 14'h030, 0, 32'h55AA55AA, 0, 1, 0);
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 2'b10; addr = 14'h030; wdata = 32'hCAFEF00D;
      @(posedge clk);
      #1 req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst/ready", {31'd0, ready}, 32'd0);
      check("mid_rst/busy",  {31'd0, busy},  32'd0);
      check("mid_rst/rdata", rdata, 32'd0);
      reset = 1'b1;
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ready) extra++;
      end
      check("mid_rst/no_ready", extra, 0);
      access("ld_w30b",  0, 2'b10, 0, 14'h030, 0, 32'h55AA55AA, 0, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end
endmodule
`default_nettype wire
